uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single `uart` transmitter between `NUM_REQ` byte producers, such as the RX loopback path, a status reporter and a debug dumper. The block sits between the requesters and the `uart` `tx_start`/`tx_data`/`tx_busy` ports. It latches the winning byte, issues a one-cycle `tx_start`, tracks `tx_busy` through the frame, and returns a completion pulse to the granted requester. A missing `tx_busy` response is caught by a timeout so that the arbiter cannot hang.

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/rr_select.sv | 46 ++++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_arb_pkg                                                 |
// | Description : Shared types and constants for the UART transmit arbiter.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_arb_pkg;

  localparam int c_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_t;

  // Index width that stays at least one bit wide for tiny requester counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_select                                                    |
// | Description : Combinational round-robin picker; search starts at last+1.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_select
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;

  // last+off never exceeds 2*NUM_REQ-1, so one conditional subtract is a full modulo.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    w_sum      = '0;
    w_cand     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_sum = {1'b0, last} + (IDX_W+1)'(off);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
        w_cand = IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ));
      end else begin
        w_cand = w_sum[IDX_W-1:0];
      end
      if (!valid && req[w_cand]) begin
        valid          = 1'b1;
        winner[w_cand] = 1'b1;
        winner_idx     = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                              |
// | Description : Round-robin sharing of one UART transmitter among requesters.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [c_DATA_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic                          tx_start,
  output logic [c_DATA_W-1:0]           tx_data,
  input  logic                          tx_busy,
  output logic                          arb_busy
);

  localparam int               c_IDX_W    = idx_width(NUM_REQ);
  localparam int               c_CNT_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_REQ - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(BUSY_TIMEOUT);

  arb_state_t             r_state,    w_state_nxt;
  logic [NUM_REQ-1:0]     r_grant,    w_grant_nxt;
  logic [NUM_REQ-1:0]     r_done,     w_done_nxt;
  logic                   r_err,      w_err_nxt;
  logic                   r_tx_start, w_tx_start_nxt;
  logic [c_DATA_W-1:0]    r_tx_data,  w_tx_data_nxt;
  logic [c_IDX_W-1:0]     r_last,     w_last_nxt;
  logic [c_CNT_W-1:0]     r_cnt,      w_cnt_nxt;
  logic                   r_arb_busy;

  logic [NUM_REQ-1:0]     w_sel_gnt;
  logic [c_IDX_W-1:0]     w_sel_idx;
  logic                   w_sel_valid;
  logic [c_DATA_W-1:0]    w_bytes [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign w_bytes[gi] = req_data[c_DATA_W*gi +: c_DATA_W];
  end

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rr_select (
    .req        (req),
    .last       (r_last),
    .winner     (w_sel_gnt),
    .winner_idx (w_sel_idx),
    .valid      (w_sel_valid)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_done_nxt     = '0;
    w_err_nxt      = 1'b0;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_last_nxt     = r_last;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      ST_IDLE: begin
        // An external user holding tx_busy blocks arbitration entirely.
        if (w_sel_valid && !tx_busy) begin
          w_state_nxt    = ST_WAIT_BUSY;
          w_grant_nxt    = w_sel_gnt;
          w_tx_data_nxt  = w_bytes[w_sel_idx];
          w_tx_start_nxt = 1'b1;
          w_last_nxt     = w_sel_idx;
          w_cnt_nxt      = '0;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_cnt == c_CNT_MAX) begin
          // Pointer already advanced past the failed requester.
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = r_grant;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_last     <= c_LAST_RST;
      r_cnt      <= '0;
      r_arb_busy <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
      r_arb_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign grant    = r_grant;
  assign done     = r_done;
  assign err      = r_err;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign arb_busy = r_arb_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                           |
// | Description : Directed bench with a UART stub and a serial line decoder.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam int BIT          = 8;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic [3:0]  req      = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  grant, done;
  logic        err, tx_start, arb_busy;
  logic [7:0]  tx_data;
  wire         tx_busy;

  // Stub: mode 0 = busy 2 cycles after start for 20 cycles, 1 = never busy, 2 = serial frame.
  logic        stub_busy = 1'b0;
  logic        ext_busy  = 1'b0;
  int          stub_mode = 0;
  logic        pre       = 1'b0;
  int          hold      = 0;
  logic [9:0]  ser_sh    = '1;
  int          ser_tmr   = 0;
  int          ser_bits  = 0;
  wire         txd;

  int          dec_cnt     = 0;
  logic [7:0]  dec_sh      = '0;
  logic [7:0]  dec_byte    = '0;
  int          dec_count   = 0;
  logic        dec_stop_ok = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n, fall_n, grant_bad, dcnt, bad;
  logic        prev_busy;

  assign tx_busy = stub_busy | ext_busy;
  assign txd     = ser_sh[0];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .arb_busy (arb_busy)
  );

  always @(posedge clk) begin
    case (stub_mode)
      0: begin
        if (tx_start) begin
          pre <= 1'b1;
        end else if (pre) begin
          pre       <= 1'b0;
          stub_busy <= 1'b1;
          hold      <= 20;
        end else if (stub_busy) begin
          if (hold == 1) stub_busy <= 1'b0;
          else           hold      <= hold - 1;
        end
      end
      2: begin
        if (tx_start && !stub_busy) begin
          stub_busy <= 1'b1;
          ser_sh    <= {1'b1, tx_data, 1'b0};
          ser_tmr   <= 0;
          ser_bits  <= 0;
        end else if (stub_busy) begin
          if (ser_tmr == BIT-1) begin
            ser_tmr  <= 0;
            ser_sh   <= {1'b1, ser_sh[9:1]};
            ser_bits <= ser_bits + 1;
            if (ser_bits == 9) stub_busy <= 1'b0;
          end else begin
            ser_tmr <= ser_tmr + 1;
          end
        end
      end
      default: ;
    endcase
  end

  // Line decoder: samples mid-bit, LSB first.
  always @(posedge clk) begin
    if (dec_cnt == 0) begin
      if (txd == 1'b0) dec_cnt <= 1;
    end else begin
      dec_cnt <= dec_cnt + 1;
      if (dec_cnt >= BIT/2 + BIT && dec_cnt <= BIT/2 + 8*BIT && ((dec_cnt - BIT/2) % BIT) == 0)
        dec_sh <= {txd, dec_sh[7:1]};
      if (dec_cnt == BIT/2 + 9*BIT) begin
        dec_byte    <= dec_sh;
        dec_stop_ok <= txd;
        dec_count   <= dec_count + 1;
        dec_cnt     <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_xfer(input string tag, input int idx, input logic [7:0] exp_byte,
                             input logic [3:0] req_after, input int exp_wait);
    int w;
    int sd;
    w  = 0;
    sd = 0;
    do begin
      tick();
      w++;
      if (done != 0) sd++;
    end while (!tx_start && w < 100);
    check_eq({tag, "_start"}, tx_start, 1);
    check_eq({tag, "_grant"}, grant, 4'b1 << idx);
    check_eq({tag, "_data"}, tx_data, exp_byte);
    check_eq({tag, "_stray_done"}, sd, 0);
    if (exp_wait >= 0) check_eq({tag, "_wait"}, w, exp_wait);
    w = 0;
    do begin
      tick();
      w++;
    end while (done == 0 && w < 200);
    check_eq({tag, "_done"}, done, 4'b1 << idx);
    check_eq({tag, "_grant_clr"}, grant, 0);
    req = req_after;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) tick();
    check_eq("rst_init", {grant, done, err, tx_start, tx_data, arb_busy}, 0);
    reset = 1'b1;
    tick();
    check_eq("idle_arb_busy", arb_busy, 0);

    // Single request; req drop and data change after grant are ignored
    req_data = 32'hA3A2_A130;
    req      = 4'b0001;
    tick();
    check_eq("t1_start", tx_start, 1);
    check_eq("t1_data", tx_data, 8'h30);
    check_eq("t1_grant", grant, 4'b0001);
    check_eq("t1_arb_busy", arb_busy, 1);
    req            = 4'b0000;
    req_data[7:0]  = 8'hFF;
    tick();
    check_eq("t1_start_width", tx_start, 0);
    n = 0; fall_n = -1; grant_bad = 0; prev_busy = tx_busy;
    do begin
      if (grant !== 4'b0001) grant_bad++;
      tick();
      n++;
      if (fall_n < 0 && prev_busy && !tx_busy) fall_n = n;
      prev_busy = tx_busy;
    end while (done == 0 && n < 100);
    check_eq("t1_done", done, 4'b0001);
    check_eq("t1_grant_held", grant_bad, 0);
    check_eq("t1_done_lat", n - fall_n, 1);
    check_eq("t1_data_hold", tx_data, 8'h30);
    tick();
    check_eq("t1_done_pulse", done, 0);

    // External tx_busy blocks arbitration
    req_data = 32'hA3A2_A1A0;
    ext_busy = 1'b1;
    req      = 4'b0010;
    bad      = 0;
    repeat (4) begin
      tick();
      if (tx_start || grant != 0) bad++;
    end
    check_eq("blk_none", bad, 0);
    ext_busy = 1'b0;
    expect_xfer("blk", 1, 8'hA1, 4'b0000, 1);

    // Timeout: tx_busy never rises
    stub_mode = 1;
    req       = 4'b0100;
    n = 0;
    do begin tick(); n++; end while (!tx_start && n < 20);
    check_eq("to_start", tx_start, 1);
    check_eq("to_grant", grant, 4'b0100);
    n = 0; dcnt = 0;
    do begin
      tick();
      n++;
      if (done != 0) dcnt++;
    end while (!err && n < 40);
    check_eq("to_err", err, 1);
    check_eq("to_lat", n, 17);
    check_eq("to_grant_clr", grant, 0);
    check_eq("to_no_done", dcnt, 0);
    check_eq("to_arb_idle", arb_busy, 0);
    stub_mode = 0;
    req       = 4'b0101;
    expect_xfer("to_next", 0, 8'hA0, 4'b0000, 1);

    // Skip and wrap from last=2
    req = 4'b0100;
    expect_xfer("sw_prep", 2, 8'hA2, 4'b0000, 1);
    req = 4'b0011;
    expect_xfer("sw_first", 0, 8'hA0, 4'b0010, 1);
    expect_xfer("sw_second", 1, 8'hA1, 4'b0000, 1);

    // Reset mid-frame, then fairness from requester 0
    req = 4'b0001;
    n = 0;
    do begin tick(); n++; end while (!tx_start && n < 20);
    repeat (5) tick();
    check_eq("rst_in_frame", arb_busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_async_outputs", {grant, done, err, tx_start, tx_data, arb_busy}, 0);
    dcnt = 0;
    repeat (25) begin
      tick();
      if (done != 0) dcnt++;
    end
    check_eq("rst_no_done", dcnt, 0);
    check_eq("rst_busy_gone", tx_busy, 0);
    reset = 1'b1;
    req   = 4'b1111;
    expect_xfer("fair0", 0, 8'hA0, 4'b1111, 1);
    expect_xfer("fair1", 1, 8'hA1, 4'b1111, 1);
    expect_xfer("fair2", 2, 8'hA2, 4'b1111, 1);
    expect_xfer("fair3", 3, 8'hA3, 4'b1111, 1);
    expect_xfer("fair4", 0, 8'hA0, 4'b0000, 1);

    // Serial frame through a UART model
    stub_mode     = 2;
    req_data[7:0] = 8'h30;
    req           = 4'b0001;
    expect_xfer("uart", 0, 8'h30, 4'b0000, 1);
    check_eq("uart_frames", dec_count, 1);
    check_eq("uart_byte", dec_byte, 8'h30);
    check_eq("uart_stop", dec_stop_ok, 1);
    check_eq("uart_line_idle", txd, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
